// File: rtl/vga_timing_pkg.sv
// Shared types and default timing for the VGA timing generator.
// Default constants describe 640x480@60 (25.175 MHz pixel clock).
package vga_timing_pkg;

  // Phase of one axis; the order is the order the count walks through.
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Phase that owns a given axis position. A zero-width porch never owns a
  // position, so the last position of a line maps to the last non-empty phase.
  function automatic phase_e phase_of(input int pos, input int act,
                                      input int fp, input int syn);
    phase_e ph;
    if (pos < act) begin
      ph = PH_ACTIVE;
    end else if (pos < act + fp) begin
      ph = PH_FRONT;
    end else if (pos < act + fp + syn) begin
      ph = PH_SYNC;
    end else begin
      ph = PH_BACK;
    end
    return ph;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: a wrapping position counter plus its phase FSM.
// The counter and phase advance together on 'step'; RST_CNT selects the
// position loaded by reset and the phase is derived from it.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int ACT     = 640,
  parameter int FP      = 16,
  parameter int SYN     = 96,
  parameter int BP      = 48,
  parameter int CNT_W   = 11,
  parameter int RST_CNT = ACT + FP + SYN + BP - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output phase_e           ph_next
);

  localparam int TOTAL = ACT + FP + SYN + BP;

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(ACT - 1);
  localparam logic [CNT_W-1:0] LAST_F = CNT_W'(ACT + FP - 1);
  localparam logic [CNT_W-1:0] LAST_S = CNT_W'(ACT + FP + SYN - 1);

  // Successor of each phase, skipping any zero-width phase in the same step.
  localparam phase_e AFTER_ACT = (FP > 0)  ? PH_FRONT :
                                 (SYN > 0) ? PH_SYNC  :
                                 (BP > 0)  ? PH_BACK  : PH_ACTIVE;
  localparam phase_e AFTER_FP  = (SYN > 0) ? PH_SYNC  :
                                 (BP > 0)  ? PH_BACK  : PH_ACTIVE;
  localparam phase_e AFTER_SYN = (BP > 0)  ? PH_BACK  : PH_ACTIVE;

  localparam logic [CNT_W-1:0] RST_C  = CNT_W'(RST_CNT);
  localparam phase_e           RST_PH = phase_of(RST_CNT, ACT, FP, SYN);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  phase_e           ph_r;
  phase_e           ph_next_s;

  // Next count and phase: a phase ends on the step that leaves its last position.
  always_comb begin
    cnt_next_s = cnt_r;
    ph_next_s  = ph_r;
    if (step) begin
      if (cnt_r == LAST_C) begin
        cnt_next_s = {CNT_W{1'b0}};
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end
      case (ph_r)
        PH_ACTIVE: if (cnt_r == LAST_A) ph_next_s = AFTER_ACT; else ph_next_s = ph_r;
        PH_FRONT:  if (cnt_r == LAST_F) ph_next_s = AFTER_FP;  else ph_next_s = ph_r;
        PH_SYNC:   if (cnt_r == LAST_S) ph_next_s = AFTER_SYN; else ph_next_s = ph_r;
        PH_BACK:   if (cnt_r == LAST_C) ph_next_s = PH_ACTIVE; else ph_next_s = ph_r;
        default:   ph_next_s = ph_r;
      endcase
    end else begin
      cnt_next_s = cnt_r;
      ph_next_s  = ph_r;
    end
  end

  // Count and phase state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= RST_C;
      ph_r  <= RST_PH;
    end else begin
      cnt_r <= cnt_next_s;
      ph_r  <= ph_next_s;
    end
  end

  assign cnt     = cnt_r;
  assign ph_next = ph_next_s;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, H/V axis timers and registered
// sync / visible / start-pulse outputs. Defining VGA_TIMING_PREFETCH_EN adds
// fetch_x/fetch_y/fetch_valid, a second axis pair running PREFETCH pixels ahead.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIX_DIV   = 1,
  parameter int CNT_W     = 11,
  parameter int PREFETCH  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [CNT_W-1:0] fetch_x,
  output logic [CNT_W-1:0] fetch_y,
  output logic             fetch_valid
`endif
);

  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HTOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VTOTAL - 1);
  localparam logic [3:0]       DIV_LAST = 4'(PIX_DIV - 1);
  localparam logic             HS_ON    = HSYNC_POL;
  localparam logic             HS_OFF   = !HSYNC_POL;
  localparam logic             VS_ON    = VSYNC_POL;
  localparam logic             VS_OFF   = !VSYNC_POL;

  // Elaboration-time parameter range checks.
  if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_pix_div
    $error("vga_timing_gen: PIX_DIV must be 1..16");
  end
  if (PREFETCH < 1 || PREFETCH > H_ACTIVE) begin : g_bad_prefetch
    $error("vga_timing_gen: PREFETCH must be 1..H_ACTIVE");
  end
  if ((2 ** CNT_W) < HTOTAL || (2 ** CNT_W) < VTOTAL) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too small for HTOTAL/VTOTAL");
  end

  logic [3:0]       div_r;
  logic             pix_ce_s;
  logic [CNT_W-1:0] h_cnt_s;
  logic [CNT_W-1:0] v_cnt_s;
  phase_e           h_ph_next_s;
  phase_e           v_ph_next_s;
  logic             h_last_s;
  logic             v_last_s;
  logic             hsync_r;
  logic             vsync_r;
  logic             visible_r;
  logic             line_start_r;
  logic             frame_start_r;

  assign pix_ce_s = en & (div_r == DIV_LAST);
  assign h_last_s = (h_cnt_s == H_LAST);
  assign v_last_s = (v_cnt_s == V_LAST);

  // Pixel divider: counts while enabled, holds while paused.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r <= 4'd0;
    end else if (en) begin
      if (div_r == DIV_LAST) begin
        div_r <= 4'd0;
      end else begin
        div_r <= div_r + 4'd1;
      end
    end else begin
      div_r <= div_r;
    end
  end

  vga_axis_timer #(
    .ACT(H_ACTIVE), .FP(H_FP), .SYN(H_SYNC), .BP(H_BP),
    .CNT_W(CNT_W), .RST_CNT(HTOTAL - 1)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .step(pix_ce_s),
    .cnt(h_cnt_s), .ph_next(h_ph_next_s)
  );

  vga_axis_timer #(
    .ACT(V_ACTIVE), .FP(V_FP), .SYN(V_SYNC), .BP(V_BP),
    .CNT_W(CNT_W), .RST_CNT(VTOTAL - 1)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .step(pix_ce_s & h_last_s),
    .cnt(v_cnt_s), .ph_next(v_ph_next_s)
  );

  // Decoded outputs, loaded on the same step as the counters so they describe
  // the new position; pulses drop while paused and on any non-zero position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_r       <= HS_OFF;
      vsync_r       <= VS_OFF;
      visible_r     <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (!en) begin
      hsync_r       <= hsync_r;
      vsync_r       <= vsync_r;
      visible_r     <= visible_r;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (pix_ce_s) begin
      hsync_r       <= (h_ph_next_s == PH_SYNC) ? HS_ON : HS_OFF;
      vsync_r       <= (v_ph_next_s == PH_SYNC) ? VS_ON : VS_OFF;
      visible_r     <= (h_ph_next_s == PH_ACTIVE) && (v_ph_next_s == PH_ACTIVE);
      line_start_r  <= h_last_s;
      frame_start_r <= h_last_s & v_last_s;
    end else begin
      hsync_r       <= hsync_r;
      vsync_r       <= vsync_r;
      visible_r     <= visible_r;
      line_start_r  <= line_start_r;
      frame_start_r <= frame_start_r;
    end
  end

  assign pix_ce      = pix_ce_s;
  assign hcount      = h_cnt_s;
  assign vcount      = v_cnt_s;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign visible     = visible_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;

`ifdef VGA_TIMING_PREFETCH_EN
  // Fetch pair: reset PREFETCH steps past the main reset position, which is
  // (PREFETCH-1, 0) since the main counters reset to the last raster position.
  logic [CNT_W-1:0] fh_cnt_s;
  logic [CNT_W-1:0] fv_cnt_s;
  phase_e           fh_ph_next_s;
  phase_e           fv_ph_next_s;
  logic             fetch_valid_r;

  vga_axis_timer #(
    .ACT(H_ACTIVE), .FP(H_FP), .SYN(H_SYNC), .BP(H_BP),
    .CNT_W(CNT_W), .RST_CNT(PREFETCH - 1)
  ) u_fh_axis (
    .clk(clk), .rst_n(rst_n), .step(pix_ce_s),
    .cnt(fh_cnt_s), .ph_next(fh_ph_next_s)
  );

  vga_axis_timer #(
    .ACT(V_ACTIVE), .FP(V_FP), .SYN(V_SYNC), .BP(V_BP),
    .CNT_W(CNT_W), .RST_CNT(0)
  ) u_fv_axis (
    .clk(clk), .rst_n(rst_n), .step(pix_ce_s & (fh_cnt_s == H_LAST)),
    .cnt(fv_cnt_s), .ph_next(fv_ph_next_s)
  );

  // Fetch visibility tracks the fetch phases; the reset position is always
  // inside the first active line because PREFETCH <= H_ACTIVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_valid_r <= 1'b1;
    end else begin
      fetch_valid_r <= (fh_ph_next_s == PH_ACTIVE) && (fv_ph_next_s == PH_ACTIVE);
    end
  end

  assign fetch_x     = fh_cnt_s;
  assign fetch_y     = fv_cnt_s;
  assign fetch_valid = fetch_valid_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance for directed timing
// checks and a tiny raster instance (PIX_DIV=4, zero-width porches, positive
// syncs) driven with random enable/reset against a raster-index model.
module tb_vga_timing_gen;

  localparam int B_HA = 8, B_HFP = 0, B_HS = 3, B_HBP = 2;
  localparam int B_VA = 4, B_VFP = 1, B_VS = 2, B_VBP = 0;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;
  localparam int B_PD = 4;
  localparam int B_PF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_rst_n = 1'b0, a_en = 1'b0;
  logic        a_pix_ce, a_hsync, a_vsync, a_visible, a_ls, a_fs;
  logic [10:0] a_hcount, a_vcount;
  logic        b_rst_n = 1'b0, b_en = 1'b0;
  logic        b_pix_ce, b_hsync, b_vsync, b_visible, b_ls, b_fs;
  logic [4:0]  b_hcount, b_vcount;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [10:0] a_fx, a_fy;
  logic        a_fv;
  logic [4:0]  b_fx, b_fy;
  logic        b_fv;
`endif

  vga_timing_gen u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .en(a_en), .pix_ce(a_pix_ce),
    .hcount(a_hcount), .vcount(a_vcount), .hsync(a_hsync), .vsync(a_vsync),
    .visible(a_visible), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_PREFETCH_EN
    , .fetch_x(a_fx), .fetch_y(a_fy), .fetch_valid(a_fv)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_DIV(B_PD), .CNT_W(5),
    .PREFETCH(B_PF)
  ) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .en(b_en), .pix_ce(b_pix_ce),
    .hcount(b_hcount), .vcount(b_vcount), .hsync(b_hsync), .vsync(b_vsync),
    .visible(b_visible), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TIMING_PREFETCH_EN
    , .fetch_x(b_fx), .fetch_y(b_fy), .fetch_valid(b_fv)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0;
    a_en    = 1'b1;
    repeat (3) tick();
    total += 7;
    if (a_hcount !== 11'd799) begin bad++; $display("FAIL rst_hcount got %0d want 799", a_hcount); end
    if (a_vcount !== 11'd524) begin bad++; $display("FAIL rst_vcount got %0d want 524", a_vcount); end
    if (a_hsync !== 1'b1) begin bad++; $display("FAIL rst_hsync got %b want 1", a_hsync); end
    if (a_vsync !== 1'b1) begin bad++; $display("FAIL rst_vsync got %b want 1", a_vsync); end
    if (a_visible !== 1'b0) begin bad++; $display("FAIL rst_visible got %b want 0", a_visible); end
    if ({a_ls, a_fs} !== 2'b00) begin bad++; $display("FAIL rst_pulses got %b want 00", {a_ls, a_fs}); end
    if (a_pix_ce !== 1'b1) begin bad++; $display("FAIL rst_pix_ce got %b want 1", a_pix_ce); end
`ifdef VGA_TIMING_PREFETCH_EN
    total++;
    if ({a_fx, a_fy, a_fv} !== {11'd1, 11'd0, 1'b1}) begin
      bad++; $display("FAIL rst_fetch got %0d,%0d,%b want 1,0,1", a_fx, a_fy, a_fv);
    end
`endif
    a_rst_n = 1'b1;
    tick();
    total++;
    if ({a_hcount, a_vcount, a_visible, a_ls, a_fs} !== {11'd0, 11'd0, 3'b111}) begin
      bad++;
      $display("FAIL first_step got h=%0d v=%0d vis=%b ls=%b fs=%b want 0,0,1,1,1",
               a_hcount, a_vcount, a_visible, a_ls, a_fs);
    end
  endtask

  task automatic test_line();
    int vis_n = 0;
    int eh, ev;
    for (int i = 1; i <= 800; i++) begin
      tick();
      eh = i % 800;
      ev = i / 800;
      if (a_visible === 1'b1) vis_n++;
      total += 5;
      if (a_hcount !== 11'(eh) || a_vcount !== 11'(ev)) begin
        bad++; $display("FAIL line_pos got %0d,%0d want %0d,%0d", a_hcount, a_vcount, eh, ev);
      end
      if (a_hsync !== !(eh >= 656 && eh < 752)) begin
        bad++; $display("FAIL line_hsync h=%0d got %b", eh, a_hsync);
      end
      if (a_visible !== (eh < 640)) begin
        bad++; $display("FAIL line_visible h=%0d got %b", eh, a_visible);
      end
      if (a_ls !== (eh == 0) || a_fs !== 1'b0) begin
        bad++; $display("FAIL line_pulses h=%0d got ls=%b fs=%b", eh, a_ls, a_fs);
      end
      if (a_vsync !== 1'b1) begin
        bad++; $display("FAIL line_vsync h=%0d got %b want 1", eh, a_vsync);
      end
    end
    total++;
    if (vis_n != 640) begin bad++; $display("FAIL line_vis_count got %0d want 640", vis_n); end
  endtask

  task automatic test_pause();
    repeat (638) tick();
`ifdef VGA_TIMING_PREFETCH_EN
    total++;
    if ({a_fx, a_fy, a_fv} !== {11'd640, 11'd1, 1'b0}) begin
      bad++; $display("FAIL fetch_638 got %0d,%0d,%b want 640,1,0", a_fx, a_fy, a_fv);
    end
`endif
    tick();
    a_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({a_hcount, a_vcount, a_visible, a_ls, a_fs, a_hsync, a_pix_ce} !==
          {11'd639, 11'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL pause_freeze got h=%0d v=%0d vis=%b ls=%b fs=%b hs=%b ce=%b",
                 a_hcount, a_vcount, a_visible, a_ls, a_fs, a_hsync, a_pix_ce);
      end
    end
    a_en = 1'b1;
    tick();
    total++;
    if ({a_hcount, a_visible} !== {11'd640, 1'b0}) begin
      bad++; $display("FAIL pause_resume got h=%0d vis=%b want 640,0", a_hcount, a_visible);
    end
  endtask

  task automatic test_mid_reset();
    repeat (60) tick();
    total++;
    if ({a_hcount, a_hsync} !== {11'd700, 1'b0}) begin
      bad++; $display("FAIL mid_pre got h=%0d hs=%b want 700,0", a_hcount, a_hsync);
    end
    a_rst_n = 1'b0;
    tick();
    total++;
    if ({a_hcount, a_vcount, a_hsync, a_visible} !== {11'd799, 11'd524, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset got h=%0d v=%0d hs=%b vis=%b want 799,524,1,0",
               a_hcount, a_vcount, a_hsync, a_visible);
    end
    a_rst_n = 1'b1;
    tick();
    total++;
    if ({a_hcount, a_vcount, a_fs, a_ls} !== {11'd0, 11'd0, 2'b11}) begin
      bad++; $display("FAIL mid_restart got h=%0d v=%0d fs=%b ls=%b", a_hcount, a_vcount, a_fs, a_ls);
    end
  endtask

  // Random enable/reset on the tiny raster; the model tracks a linear raster
  // index and derives every output from the porch/sync widths.
  task automatic test_random_small();
    int  tot = B_HT * B_VT;
    int  m_div = 0, m_idx = B_HT * B_VT - 1;
    int  h, v, fi, fx, fy;
    bit  m_run = 0, m_ls = 0, m_fs = 0, ce;
    bit  e_hs, e_vs, e_vis, e_fv;
    for (int i = 0; i < 4000; i++) begin
      b_en    = ($urandom_range(9, 0) < 8);
      b_rst_n = (i < 2) ? 1'b0 : ($urandom_range(599, 0) != 0);
      #1;
      ce = b_en && (m_div == B_PD - 1);
      total++;
      if (b_pix_ce !== ce) begin bad++; $display("FAIL rnd_pix_ce i=%0d got %b want %b", i, b_pix_ce, ce); end
      @(posedge clk);
      if (!b_rst_n) begin
        m_div = 0; m_idx = tot - 1; m_run = 0; m_ls = 0; m_fs = 0;
      end else begin
        if (b_en) m_div = (m_div == B_PD - 1) ? 0 : m_div + 1;
        if (ce) begin
          m_idx = (m_idx + 1) % tot;
          m_run = 1;
          m_ls  = (m_idx % B_HT == 0);
          m_fs  = (m_idx == 0);
        end else if (!b_en) begin
          m_ls = 0;
          m_fs = 0;
        end
      end
      #1;
      h     = m_idx % B_HT;
      v     = m_idx / B_HT;
      e_hs  = m_run && (h >= B_HA + B_HFP) && (h < B_HA + B_HFP + B_HS);
      e_vs  = m_run && (v >= B_VA + B_VFP) && (v < B_VA + B_VFP + B_VS);
      e_vis = m_run && (h < B_HA) && (v < B_VA);
      total += 4;
      if (b_hcount !== 5'(h) || b_vcount !== 5'(v)) begin
        bad++; $display("FAIL rnd_pos i=%0d got %0d,%0d want %0d,%0d", i, b_hcount, b_vcount, h, v);
      end
      if (b_hsync !== e_hs || b_vsync !== e_vs) begin
        bad++; $display("FAIL rnd_sync i=%0d got %b%b want %b%b", i, b_hsync, b_vsync, e_hs, e_vs);
      end
      if (b_visible !== e_vis) begin
        bad++; $display("FAIL rnd_visible i=%0d got %b want %b", i, b_visible, e_vis);
      end
      if (b_ls !== m_ls || b_fs !== m_fs) begin
        bad++; $display("FAIL rnd_pulses i=%0d got %b%b want %b%b", i, b_ls, b_fs, m_ls, m_fs);
      end
`ifdef VGA_TIMING_PREFETCH_EN
      fi   = (m_idx + B_PF) % tot;
      fx   = fi % B_HT;
      fy   = fi / B_HT;
      e_fv = (fx < B_HA) && (fy < B_VA);
      total++;
      if (b_fx !== 5'(fx) || b_fy !== 5'(fy) || b_fv !== e_fv) begin
        bad++; $display("FAIL rnd_fetch i=%0d got %0d,%0d,%b want %0d,%0d,%b",
                        i, b_fx, b_fy, b_fv, fx, fy, e_fv);
      end
`endif
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_line();
    test_pause();
    test_mid_reset();
    test_random_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
